// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator, MSB first.
// Registered equal/greater/less results with a one-cycle done pulse.
module serial_mag_comp #(
    parameter int WIDTH      = 4,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             less
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             greater_q, greater_d;
    logic             less_q, less_d;

    logic ready;
    logic accept;
    logic bit_a;
    logic bit_b;
    logic decided;
    logic gt_now;
    logic lt_now;
    logic last;

    always_comb begin
        ready   = (state_q == IDLE) || (state_q == DONE);
        accept  = ready && start;
        bit_a   = sa_q[WIDTH-1];
        bit_b   = sb_q[WIDTH-1];
        decided = gt_q || lt_q;
        // Only the first differing bit decides the result.
        gt_now  = gt_q || (!decided && bit_a && !bit_b);
        lt_now  = lt_q || (!decided && !bit_a && bit_b);
        last    = (cnt_q == '0) || (EARLY_EXIT && (gt_now || lt_now));

        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        eq_d      = eq_q;
        greater_d = greater_q;
        less_d    = less_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    sa_d      = a;
                    sb_d      = b;
                    cnt_d     = CNT_INIT;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                    eq_d      = 1'b0;
                    greater_d = 1'b0;
                    less_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sa_d  = sa_q << 1;
                sb_d  = sb_q << 1;
                cnt_d = cnt_q - CW'(1);
                gt_d  = gt_now;
                lt_d  = lt_now;
                if (last) begin
                    state_d   = DONE;
                    greater_d = gt_now;
                    less_d    = lt_now;
                    eq_d      = !(gt_now || lt_now);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            eq_q      <= eq_d;
            greater_q <= greater_d;
            less_q    <= less_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign equal   = eq_q;
    assign greater = greater_q;
    assign less    = less_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed bench for serial_mag_comp, WIDTH=4,
// full-scan and early-exit instances side by side.
`timescale 1ns/1ps
module tb_serial_mag_comp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;

    logic busy_0, done_0, eq_0, gt_0, lt_0;
    logic busy_1, done_1, eq_1, gt_1, lt_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_mag_comp #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy_0), .done(done_0), .equal(eq_0),
        .greater(gt_0), .less(lt_0)
    );

    serial_mag_comp #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy_1), .done(done_1), .equal(eq_1),
        .greater(gt_1), .less(lt_1)
    );

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic       eg;
        logic       el;
        int         lat1;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int lat_ee(input logic [3:0] x, input logic [3:0] y);
        for (int i = 3; i >= 0; i--)
            if (x[i] != y[i]) return (4 - i) + 1;
        return 5;
    endfunction

    task automatic run_cmp(input logic [3:0] va, input logic [3:0] vb,
                           input logic eg, input logic el,
                           input int lat1, input bit hold);
        int   k, l0, l1, nbusy;
        logic g0, s0, e0, g1, s1, e1;
        logic ee;
        ee = !(eg || el);
        l0 = 0; l1 = 0; nbusy = 0;
        g0 = 0; s0 = 0; e0 = 0; g1 = 0; s1 = 0; e1 = 0;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb;
        k = 1;
        while (k <= 12 && (l0 == 0 || l1 == 0)) begin
            if (l0 == 0 && busy_0) nbusy++;
            if (done_0 && l0 == 0) begin
                l0 = k; g0 = gt_0; s0 = lt_0; e0 = eq_0;
            end
            if (done_1 && l1 == 0) begin
                l1 = k; g1 = gt_1; s1 = lt_1; e1 = eq_1;
            end
            if (l0 == 0 || l1 == 0) begin
                @(negedge clk);
                k++;
            end
        end
        chk("lat_full", l0, 5);
        chk("lat_early", l1, lat1);
        chk("res_full", {e0, g0, s0}, {ee, eg, el});
        chk("res_early", {e1, g1, s1}, {ee, eg, el});
        if (hold) begin
            chk("busy_cycles", nbusy, 4);
            for (int h = 0; h < 3; h++) begin
                @(negedge clk);
                chk("hold_full", {done_0, busy_0, eq_0, gt_0, lt_0},
                    {1'b0, 1'b0, ee, eg, el});
                chk("hold_early", {done_1, busy_1, eq_1, gt_1, lt_1},
                    {1'b0, 1'b0, ee, eg, el});
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        logic [3:0] pa[3];
        logic [3:0] pb[3];
        logic [2:0] pr[3];
        int n, ndone;
        logic [3:0] x, y;

        vecs[0] = '{4'b0101, 4'b0101, 1'b0, 1'b0, 5};
        vecs[1] = '{4'b1001, 4'b1010, 1'b0, 1'b1, 4};
        vecs[2] = '{4'b1000, 4'b0111, 1'b1, 1'b0, 2};
        vecs[3] = '{4'b0110, 4'b0111, 1'b0, 1'b1, 5};
        vecs[4] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 2};
        vecs[5] = '{4'b0000, 4'b0001, 1'b0, 1'b1, 5};
        vecs[6] = '{4'b0010, 4'b0000, 1'b1, 1'b0, 4};

        // reset with start asserted
        rst_n = 1'b0; start = 1'b1; a = 4'b0101; b = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        chk("reset_full", {busy_0, done_0, eq_0, gt_0, lt_0}, 5'b0);
        chk("reset_early", {busy_1, done_1, eq_1, gt_1, lt_1}, 5'b0);
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("reset_noaccept", {busy_0, busy_1}, 2'b0);

        foreach (vecs[i])
            run_cmp(vecs[i].va, vecs[i].vb, vecs[i].eg, vecs[i].el,
                    vecs[i].lat1, 1'b1);

        // back-to-back with start held high
        pa[0] = 4'b1100; pb[0] = 4'b1010; pr[0] = 3'b010;
        pa[1] = 4'b0011; pb[1] = 4'b0011; pr[1] = 3'b100;
        pa[2] = 4'b0100; pb[2] = 4'b1001; pr[2] = 3'b001;
        @(negedge clk);
        start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a = pa[j]; b = pb[j];
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (!done_0 && n == 2) begin
                    a = ~pa[j]; b = ~pb[j];
                end
            end while (!done_0 && n < 10);
            chk("b2b_period", n, 5);
            chk("b2b_result", {eq_0, gt_0, lt_0}, pr[j]);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        // reset in the second SHIFT cycle
        a = 4'b0101; b = 4'b0101; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_full", {busy_0, done_0, eq_0, gt_0, lt_0}, 5'b0);
        chk("abort_early", {busy_1, done_1, eq_1, gt_1, lt_1}, 5'b0);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_0 || done_1 || busy_0 || busy_1) ndone++;
        end
        chk("abort_quiet", ndone, 0);

        // exhaustive sweep
        for (int i = 0; i < 256; i++) begin
            x = i[7:4];
            y = i[3:0];
            run_cmp(x, y, x > y, x < y, lat_ee(x, y), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
